// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: registered reads with valid strobes, hardwired-zero x0,
// sequential post-reset clear. Define REGFILE_MP_BYPASS_EN for write-first same-cycle forwarding.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic                 ready
);

    // One bit per encodable address: set only for entries 1..NREGS-1, so x0 and
    // out-of-range addresses share a single check.
    function automatic logic [(1<<AW)-1:0] addr_ok_map();
        logic [(1<<AW)-1:0] m;
        m = '0;
        for (int unsigned i = 1; i < NREGS; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [(1<<AW)-1:0] ADDR_OK = addr_ok_map();

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_n;
    logic [AW-1:0]     cnt, cnt_n;
    logic [XLEN-1:0]   mem [NREGS];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic              wr_fire;
    logic [XLEN-1:0]   rd_val [NRD];

    assign wr_fire = (state == RUN) && wr_en && ADDR_OK[wr_addr];
    assign ready   = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The clear engine and the write port share one array write port.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                if (cnt == AW'(NREGS - 1)) state_n = RUN;
                else                       cnt_n   = cnt + 1'b1;
            end
            RUN: begin
                mem_we = wr_fire;
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_val[p] = ADDR_OK[rd_addr[p*AW +: AW]] ? mem[rd_addr[p*AW +: AW]] : '0;
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_fire && (wr_addr == rd_addr[p*AW +: AW])) rd_val[p] = wr_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= '0;
            if (state == RUN) begin
                for (int unsigned p = 0; p < NRD; p++) begin
                    if (rd_en[p]) begin
                        rd_data[p*XLEN +: XLEN] <= rd_val[p];
                        rd_valid[p]             <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
